cmos_ddr3_wr_packer: RTL and testbench
======================================

Name: cmos_ddr3_wr_packer

Overview:
- Sits between the OV5640 capture stage (16-bit RGB565 pixel + write-enable) and the DDR3 frame-buffer write port (128-bit, burst-based).
- Packs 8 pixels per 128-bit word and buffers words in a local FIFO.
- Issues fixed-length write bursts with frame-relative addresses and rotates through NUM_FRAMES frame buffers on each vsync.

Parameters:
- ADDR_WIDTH, 28, DDR3 address width in x16 units ({rank, bank, row, col}).
- DATA_WIDTH, 128, DDR3 user data width; fixed at 8 pixels x 16 bits.
- BURST_LEN, 16, 128-bit words per write burst (power of 2, 2..32).
- FIFO_DEPTH, 64, word FIFO depth (power of 2, >= 2*BURST_LEN).
- NUM_FRAMES, 3, frame buffers rotated (1..4).
- FRAME_BASE, 28'h0000000, address of frame 0.
- FRAME_STRIDE, 28'h0100000, address distance between frame buffers.

Ports:
- I_clk, input, 1, single clock (camera pixel clock domain).
- I_rst, input, 1, asynchronous active-high reset.
- I_vsync, input, 1, camera vsync, level; a rising edge marks frame start.
- I_pix_vld, input, 1, pixel-valid strobe.
- I_pix_data, input, 16, RGB565 pixel.
- O_burst_req, output, 1, burst request.
- O_burst_addr, output, ADDR_WIDTH, burst start address; stable while O_burst_req=1.
- I_burst_ack, input, 1, request accepted in the cycle where req & ack.
- O_wr_data, output, DATA_WIDTH, FIFO head word.
- O_wr_vld, output, 1, write-beat valid.
- I_wr_rdy, input, 1, a beat transfers when vld & rdy.
- O_frame_idx, output, 2, index of the frame buffer currently being written.
- O_overflow, output, 1, sticky: at least one word was dropped this frame.

Behaviour:
- Reset values:
  - All outputs 0.
  - Pack counter 0, FIFO empty, state IDLE.
  - Frame index 0, write address FRAME_BASE.
- Packing:
  - Pixel k of a word (k = 0..7, arrival order) goes to bits [16k+15:16k].
  - On the 8th pixel, the full word is pushed into the FIFO in that same cycle.
  - The pack register is written combinationally with the 8th pixel, so push latency is 1 clock from I_pix_vld.
- Overflow: if a push is needed while the FIFO is full and no pop occurs that cycle, the word is dropped and O_overflow is set. O_overflow clears only on a frame restart.
- Simultaneous push and pop on a full FIFO is legal: no drop occurs.
- vsync detection: I_vsync is registered once; frame start = registered low and current high (1-cycle detect latency).
- Frame start is latched as pending_restart. The restart executes when state is IDLE, or at the end of the DATA burst in progress. A restart does all of the following in one cycle:
  - Frame index becomes (idx+1) mod NUM_FRAMES.
  - Write address becomes FRAME_BASE + new_idx*FRAME_STRIDE.
  - FIFO and pack counter are cleared; residual words and the partial word are discarded.
  - O_overflow is cleared.
  - Pixels arriving while the restart is pending are discarded.
- State machine:
  - IDLE: if pending_restart, perform the restart and stay in IDLE. Else if FIFO level >= BURST_LEN, go to REQ.
  - REQ: O_burst_req=1, O_burst_addr = current address. On req & ack, go to DATA and load beat counter = BURST_LEN.
  - DATA: O_wr_vld=1 while the beat counter is nonzero; O_wr_data = FIFO head. Each vld & rdy pops the FIFO and decrements the counter. After the last beat: address += BURST_LEN*8 (wraps modulo 2^ADDR_WIDTH), then go to IDLE and apply any pending restart.
- The FIFO always holds at least BURST_LEN words on entry to DATA, so O_wr_vld never drops mid-burst.
- Back-to-back bursts: at least 1 IDLE cycle between the last beat and the next O_burst_req.
- Frame-size rule: a frame of W*H pixels must be a multiple of 8*BURST_LEN pixels (1280x720 gives 7200 bursts). Otherwise the residue is discarded at the next vsync.

Optional Feature:
- Macro PACKER_STATS_EN.
- When defined, adds the following, all reset to 0:
  - O_drop_cnt [15:0]: words dropped by overflow plus residual words discarded at restart. Saturates at 16'hFFFF and clears on I_rst only.
  - O_frame_cnt [15:0]: completed restarts, wrapping.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package cv_ddr_pkg: ADDR_WIDTH/DATA_WIDTH constants, PIX_PER_WORD=8, the burst-state enum {IDLE, REQ, DATA}, and the address-increment constant BURST_LEN*8.
- Sub-module sync_word_fifo: single-clock FIFO with push, pop, level, full and empty outputs, plus a synchronous clear input. Packing, the FSM and addressing stay in the top module.

Test Plan:
- Reset, then 128 pixels with values 0..127 and I_wr_rdy=1, I_burst_ack=1 on request:
  - exactly one burst at 28'h0000000;
  - 16 beats, beat0 = {16'd7,...,16'd1,16'd0};
  - the next address is 28'h0000080.
- Same stream with I_wr_rdy toggling every other cycle: 16 beats in order, no drops, O_wr_vld held continuously during the burst.
- Hold I_burst_ack=0 while 1000 pixels arrive: FIFO fills at 64 words, then O_overflow=1. With the stats build, O_drop_cnt counts every further completed word.
- vsync rising edge mid-burst: the burst completes all 16 beats. Then O_frame_idx becomes 1, the next address is 28'h0100000, the FIFO is empty and O_overflow=0.
- Three vsync edges with NUM_FRAMES=3: O_frame_idx goes 1, 2, 0; base addresses are 28'h0100000, 28'h0200000, 28'h0000000.
- Assert I_rst during DATA beat 5: all outputs are 0 on the same cycle, and after release the first burst again targets 28'h0000000.

Source files
------------

// File: rtl/cv_ddr_pkg.sv
// Shared constants and burst-state encoding for the camera-to-DDR3 write path.
package cv_ddr_pkg;
  localparam int CV_ADDR_WIDTH   = 28;
  localparam int CV_DATA_WIDTH   = 128;
  localparam int CV_PIX_WIDTH    = 16;
  localparam int CV_PIX_PER_WORD = 8;
  localparam int CV_BURST_LEN    = 16;
  localparam int CV_ADDR_INC     = CV_BURST_LEN * CV_PIX_PER_WORD;

  typedef enum logic [1:0] {IDLE, REQ, DATA} burst_state_e;

  // Address advance per burst, in x16 units (each word holds 8 pixels).
  function automatic int burst_addr_inc(input int burst_len);
    return burst_len * CV_PIX_PER_WORD;
  endfunction
endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO; a simultaneous push and pop on a full FIFO is accepted.
module sync_word_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/cmos_ddr3_wr_packer.sv
// Packs RGB565 pixels 8-per-word and writes them to DDR3 in fixed bursts, rotating frame buffers on vsync.
// Optional PACKER_STATS_EN adds drop and frame counters.
module cmos_ddr3_wr_packer
  import cv_ddr_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = CV_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = CV_DATA_WIDTH,
  parameter int                    BURST_LEN    = CV_BURST_LEN,
  parameter int                    FIFO_DEPTH   = 64,
  parameter int                    NUM_FRAMES   = 3,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = 28'h0000000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 28'h0100000
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_vsync,
  input  logic                  I_pix_vld,
  input  logic [15:0]           I_pix_data,
  output logic                  O_burst_req,
  output logic [ADDR_WIDTH-1:0] O_burst_addr,
  input  logic                  I_burst_ack,
  output logic [DATA_WIDTH-1:0] O_wr_data,
  output logic                  O_wr_vld,
  input  logic                  I_wr_rdy,
  output logic [1:0]            O_frame_idx,
  output logic                  O_overflow
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]           O_drop_cnt,
  output logic [15:0]           O_frame_cnt
`endif
);
  localparam int PCW = $clog2(CV_PIX_PER_WORD);
  localparam int LVW = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(burst_addr_inc(BURST_LEN));

  burst_state_e state, state_nxt;
  logic                       vsync_q, pending_restart, frame_rise, restart;
  logic [PCW-1:0]             pack_cnt;
  logic [DATA_WIDTH-17:0]     pack_reg;
  logic [BCW-1:0]             beat_cnt;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [1:0]                 frame_idx, idx_nxt;
  logic                       overflow, pix_acc, word_done, drop;
  logic                       burst_req, wr_vld, beat, last_beat;
  logic                       fifo_full, fifo_empty;
  logic [LVW-1:0]             fifo_level;
  logic [DATA_WIDTH-1:0]      fifo_rdata;

  function automatic logic [ADDR_WIDTH-1:0] frame_addr(input logic [1:0] idx);
    return FRAME_BASE + ADDR_WIDTH'(idx) * FRAME_STRIDE;
  endfunction

  assign frame_rise = I_vsync & ~vsync_q;
  assign pix_acc    = I_pix_vld & ~pending_restart;
  assign word_done  = pix_acc && (pack_cnt == PCW'(CV_PIX_PER_WORD - 1));
  assign beat       = wr_vld & I_wr_rdy;
  assign last_beat  = beat && (beat_cnt == BCW'(1));
  assign drop       = word_done && fifo_full && !beat;
  // Restart only between bursts so a burst that was granted is always completed.
  assign restart    = pending_restart && ((state == IDLE) || last_beat);
  assign idx_nxt    = (frame_idx == 2'(NUM_FRAMES - 1)) ? 2'd0 : frame_idx + 2'd1;

  sync_word_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (I_clk),
    .rst   (I_rst),
    .clr   (restart),
    .push  (word_done),
    .pop   (beat),
    .wdata ({I_pix_data, pack_reg}),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!pending_restart && fifo_level >= LVW'(BURST_LEN)) state_nxt = REQ;
      REQ:     if (I_burst_ack) state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    burst_req = (state == REQ);
    wr_vld    = (state == DATA) && (beat_cnt != '0) && !fifo_empty;
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      vsync_q         <= 1'b0;
      pending_restart <= 1'b0;
      pack_cnt        <= '0;
      pack_reg        <= '0;
      beat_cnt        <= '0;
      wr_addr         <= FRAME_BASE;
      frame_idx       <= '0;
      overflow        <= 1'b0;
    end else begin
      vsync_q         <= I_vsync;
      pending_restart <= frame_rise | (pending_restart & ~restart);
      if (restart) begin
        frame_idx <= idx_nxt;
        wr_addr   <= frame_addr(idx_nxt);
        pack_cnt  <= '0;
        overflow  <= 1'b0;
      end else begin
        if (pix_acc) begin
          if (word_done) pack_cnt <= '0;
          else begin
            pack_cnt <= pack_cnt + 1'b1;
            pack_reg[pack_cnt*16 +: 16] <= I_pix_data;
          end
        end
        if (drop)      overflow <= 1'b1;
        if (last_beat) wr_addr  <= wr_addr + ADDR_INC;
      end
      if (burst_req && I_burst_ack) beat_cnt <= BCW'(BURST_LEN);
      else if (beat)                beat_cnt <= beat_cnt - 1'b1;
    end
  end

  assign O_burst_req  = burst_req;
  assign O_burst_addr = burst_req ? wr_addr : '0;
  assign O_wr_vld     = wr_vld;
  assign O_wr_data    = wr_vld ? fifo_rdata : '0;
  assign O_frame_idx  = frame_idx;
  assign O_overflow   = overflow;

`ifdef PACKER_STATS_EN
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt, frame_cnt;

  // Words lost at restart are what the FIFO still holds after this cycle's pop.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + 17'(drop);
    if (restart) drop_sum = drop_sum + 17'(fifo_level) - 17'(beat);
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (restart) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign O_drop_cnt  = drop_cnt;
  assign O_frame_cnt = frame_cnt;
`endif
endmodule

// File: tb/tb_cmos_ddr3_wr_packer.sv
// Directed bench with a transaction-level scoreboard model of the packer.
module tb_cmos_ddr3_wr_packer;
  localparam int AW = 28, BL = 16, FD = 64, NF = 3;
  localparam logic [AW-1:0] BASE = 28'h0, STRIDE = 28'h0100000;
  localparam logic [127:0] W0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

  logic          I_clk = 1'b0;
  logic          I_rst, I_vsync, I_pix_vld, I_burst_ack, I_wr_rdy;
  logic [15:0]   I_pix_data;
  logic          O_burst_req, O_wr_vld, O_overflow;
  logic [AW-1:0] O_burst_addr;
  logic [127:0]  O_wr_data;
  logic [1:0]    O_frame_idx;
`ifdef PACKER_STATS_EN
  logic [15:0]   O_drop_cnt, O_frame_cnt;
`endif

  int n_chk = 0, n_fail = 0;
  bit rdy_tog = 1'b0;

  cmos_ddr3_wr_packer dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_vsync(I_vsync), .I_pix_vld(I_pix_vld),
    .I_pix_data(I_pix_data), .O_burst_req(O_burst_req), .O_burst_addr(O_burst_addr),
    .I_burst_ack(I_burst_ack), .O_wr_data(O_wr_data), .O_wr_vld(O_wr_vld),
    .I_wr_rdy(I_wr_rdy), .O_frame_idx(O_frame_idx), .O_overflow(O_overflow)
`ifdef PACKER_STATS_EN
    , .O_drop_cnt(O_drop_cnt), .O_frame_cnt(O_frame_cnt)
`endif
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard model: word queue, frame rotation, expected burst addresses.
  logic [127:0] q[$];
  logic [127:0] first_beat[$];
  logic [AW-1:0] cap_addr[$];
  logic [127:0] m_word;
  logic [AW-1:0] m_addr;
  int  m_pix, m_beats, m_idx, m_drop, m_fcnt, beat_total = 0;
  bit  m_ovf, m_pend, m_vs, m_gap;

  function automatic logic [AW-1:0] base_of(input int idx);
    return BASE + AW'(idx) * STRIDE;
  endfunction

  always @(negedge I_clk) begin
    bit beat, last, rs, acc;
    if (I_rst) begin
      q.delete(); m_word = '0; m_addr = BASE; m_pix = 0; m_beats = 0; m_idx = 0;
      m_drop = 0; m_fcnt = 0; m_ovf = 0; m_pend = 0; m_vs = 0; m_gap = 0;
    end else begin
      chk("frame_idx", O_frame_idx, m_idx[1:0]);
      chk("overflow", O_overflow, m_ovf);
      chk("wr_vld", O_wr_vld, m_beats > 0);
`ifdef PACKER_STATS_EN
      chk("drop_cnt", O_drop_cnt, (m_drop > 65535) ? 65535 : m_drop);
      chk("frame_cnt", O_frame_cnt, m_fcnt[15:0]);
`endif
      if (O_burst_req) begin
        chk("req_spacing", (m_beats == 0) && !m_gap, 1'b1);
        chk("req_level", q.size() >= BL, 1'b1);
      end
      beat = O_wr_vld && I_wr_rdy;
      if (beat) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wr_data: beat with data %0h but model queue empty", O_wr_data);
        end else chk("wr_data", O_wr_data, q.pop_front());
        if (m_beats == BL) first_beat.push_back(O_wr_data);
        beat_total++;
      end
      last = beat && (m_beats == 1);
      if (O_burst_req && I_burst_ack) begin
        chk("burst_addr", O_burst_addr, m_addr);
        cap_addr.push_back(O_burst_addr);
        m_addr += AW'(BL * 8);
      end
      rs  = m_pend && !O_burst_req && ((m_beats == 0) || last);
      acc = I_pix_vld && !m_pend;
      if (beat && m_beats > 0) m_beats--;
      if (O_burst_req && I_burst_ack) m_beats = BL;
      m_gap = last;
      if (rs) begin
        m_drop += q.size();
        q.delete();
        m_pix = 0;
        m_idx = (m_idx + 1) % NF;
        m_addr = base_of(m_idx);
        m_ovf = 0;
        m_fcnt++;
      end
      if (acc) begin
        m_word[m_pix*16 +: 16] = I_pix_data;
        m_pix++;
        if (m_pix == 8) begin
          m_pix = 0;
          if (q.size() >= FD) begin m_ovf = 1; m_drop++; end
          else q.push_back(m_word);
        end
      end
      m_pend = (m_pend && !rs) || (I_vsync && !m_vs);
      m_vs = I_vsync;
    end
  end

  initial forever begin
    @(posedge I_clk); #1;
    I_wr_rdy = rdy_tog ? ~I_wr_rdy : 1'b1;
  end

  task automatic send_pix(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      @(posedge I_clk); #1;
      I_pix_vld = 1'b1;
      I_pix_data = 16'(start + i);
    end
    @(posedge I_clk); #1;
    I_pix_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    n_chk++;
    for (int i = 0; i < budget && quiet < 6; i++) begin
      @(posedge I_clk); #1;
      if (!O_burst_req && !O_wr_vld) quiet++; else quiet = 0;
    end
    if (quiet < 6) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int i = 0;
    n_chk++;
    while (beat_total < target && i < budget) begin @(posedge I_clk); #1; i++; end
    if (beat_total < target) begin
      n_fail++;
      $display("FAIL wait_beats: got %0d beats expected %0d", beat_total, target);
    end
  endtask

  task automatic pulse_vsync();
    I_vsync = 1'b1;
    repeat (3) begin @(posedge I_clk); #1; end
    I_vsync = 1'b0;
    wait_idle(50);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"},   O_burst_req, 0);
    chk({tag, "_addr"},  O_burst_addr, 0);
    chk({tag, "_vld"},   O_wr_vld, 0);
    chk({tag, "_data"},  O_wr_data, 0);
    chk({tag, "_idx"},   O_frame_idx, 0);
    chk({tag, "_ovf"},   O_overflow, 0);
`ifdef PACKER_STATS_EN
    chk({tag, "_dcnt"},  O_drop_cnt, 0);
    chk({tag, "_fcnt"},  O_frame_cnt, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bt;
    I_rst = 1'b1; I_vsync = 1'b0; I_pix_vld = 1'b0; I_pix_data = '0;
    I_burst_ack = 1'b1; I_wr_rdy = 1'b1;
    repeat (3) begin @(posedge I_clk); #1; end
    check_zero("reset");
    I_rst = 1'b0;

    // One frame chunk of 128 pixels -> a single burst at frame base.
    send_pix(128, 0);
    wait_idle(400);
    chk("t1_bursts", cap_addr.size(), 1);
    chk("t1_addr", cap_addr[0], 28'h0000000);
    chk("t1_beat0", first_beat[0], W0);
    chk("t1_beats", beat_total, 16);

    // Same stream with back-pressure on every other cycle.
    rdy_tog = 1'b1;
    send_pix(128, 0);
    wait_idle(400);
    rdy_tog = 1'b0;
    chk("t2_bursts", cap_addr.size(), 2);
    chk("t2_addr", cap_addr[1], 28'h0000080);
    chk("t2_beat0", first_beat[1], W0);
    chk("t2_beats", beat_total, 32);

    // No grant while 1000 pixels arrive: 64 words kept, 61 dropped.
    I_burst_ack = 1'b0;
    send_pix(1000, 0);
    chk("t3_overflow", O_overflow, 1);
    chk("t3_req_held", O_burst_req, 1);
`ifdef PACKER_STATS_EN
    chk("t3_drop_cnt", O_drop_cnt, 61);
`endif
    I_burst_ack = 1'b1;
    wait_idle(1000);
    chk("t3_bursts", cap_addr.size(), 6);
    chk("t3_last_addr", cap_addr[5], 28'h0000280);
    chk("t3_beats", beat_total, 96);
    chk("t3_ovf_sticky", O_overflow, 1);

    // vsync during a burst: burst finishes, then frame 1.
    send_pix(128, 16'h100);
    wait_beats(99, 200);
    I_vsync = 1'b1;
    wait_idle(200);
    I_vsync = 1'b0;
    chk("t4_addr", cap_addr[6], 28'h0000300);
    chk("t4_beats", beat_total, 112);
    chk("t4_idx", O_frame_idx, 1);
    chk("t4_ovf_clr", O_overflow, 0);
    send_pix(128, 16'h200);
    wait_idle(400);
    chk("t4_next_addr", cap_addr[7], 28'h0100000);

    // Frame 2, a residue that never bursts, then wrap to frame 0.
    pulse_vsync();
    chk("t5_idx2", O_frame_idx, 2);
    send_pix(128, 16'h300);
    wait_idle(400);
    chk("t5_addr2", cap_addr[8], 28'h0200000);
    send_pix(100, 16'h400);
    wait_idle(100);
    chk("t5_no_burst", cap_addr.size(), 9);
    pulse_vsync();
    chk("t5_idx0", O_frame_idx, 0);
`ifdef PACKER_STATS_EN
    chk("t5_drop_cnt", O_drop_cnt, 73);
    chk("t5_frame_cnt", O_frame_cnt, 3);
`endif
    send_pix(128, 16'h500);
    wait_idle(400);
    chk("t5_addr0", cap_addr[9], 28'h0000000);

    // Reset in the middle of a burst.
    bt = beat_total;
    send_pix(128, 16'h600);
    wait_beats(bt + 5, 200);
    chk("t6_addr", cap_addr[10], 28'h0000080);
    I_rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    send_pix(128, 16'h700);
    wait_idle(400);
    chk("t6_post_addr", cap_addr[11], 28'h0000000);
    chk("t6_post_idx", O_frame_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
